// File: rtl/lcd_text_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lcd_text_ctrl
// Purpose  : HD44780 character-LCD controller. Runs the power-on init
//            sequence itself, then accepts one operation per valid/ready
//            handshake (char, clear, goto, raw instruction), tracks the
//            cursor and drives the panel pins with internally timed E pulses.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK        in   system clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   cmd_valid  in   operation request
//   cmd_ready  out  high in IDLE only
//   cmd_op     in   0 char, 1 clear, 2 goto, 3 raw instruction
//   cmd_data   in   character code (op 0) or instruction byte (op 3)
//   cmd_row    in   goto row
//   cmd_col    in   goto column
//   LCD_D      out  panel data bus (D7..D4 when BUS_WIDTH = 4)
//   LCD_RS     out  0 instruction, 1 data
//   LCD_E      out  enable strobe
//   init_done  out  high once the init sequence has completed
//   cur_row    out  cursor row
//   cur_col    out  cursor column
// Optional feature macro
//   LCD_AUTOWRAP_EN : after a char at the last column, append a set-DDRAM
//                     transfer to (next row, col 0) in the same busy period.
// ============================================================================
module lcd_text_ctrl #(
   parameter int CLK_FREQ_HZ = 50000000,
   parameter int BUS_WIDTH   = 4,
   parameter int COLS        = 16,
   parameter int ROWS        = 2
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic [7:0]           cmd_data,
   input  logic [1:0]           cmd_row,
   input  logic [5:0]           cmd_col,
   output logic [BUS_WIDTH-1:0] LCD_D,
   output logic                 LCD_RS,
   output logic                 LCD_E,
   output logic                 init_done,
   output logic [1:0]           cur_row,
   output logic [5:0]           cur_col
);

   localparam int T1US  = (CLK_FREQ_HZ / 1000000 < 1) ? 1 : CLK_FREQ_HZ / 1000000;
   localparam int CNT_W = $clog2(15000 * T1US + 1);

   // 4-bit mode has one extra single-nibble step (0x2) that switches to DL = 0.
   localparam logic [3:0] C_LAST_IDX = (BUS_WIDTH == 4) ? 4'd8 : 4'd7;
   localparam logic [7:0] C_FSET     = 8'h20 | ((BUS_WIDTH == 8) ? 8'h10 : 8'h00)
                                             | ((ROWS > 1)       ? 8'h08 : 8'h00);
   localparam logic [1:0] C_ROW_MAX  = 2'(ROWS - 1);
   localparam logic [5:0] C_COL_MAX  = 6'(COLS - 1);

   typedef enum logic [2:0] {
      S_PWR_WAIT = 3'd0,
      S_INIT     = 3'd1,
      S_IDLE     = 3'd2,
      S_SETUP    = 3'd3,
      S_E_HI     = 3'd4,
      S_E_LO     = 3'd5,
      S_WAIT     = 3'd6
   } state_t;

   function automatic logic [CNT_W-1:0] us_to_cnt(input int us);
      return CNT_W'(us * T1US - 1);
   endfunction

   localparam logic [CNT_W-1:0] C_CNT_1US = CNT_W'(T1US - 1);

   // Clear and home need the long execution time; everything else is short.
   function automatic logic [CNT_W-1:0] exec_cnt(input logic [7:0] b, input logic rs);
      if (!rs && (b == 8'h01 || b == 8'h02 || b == 8'h03))
         return us_to_cnt(3000);
      return us_to_cnt(53);
   endfunction

   // 8-bit mode skips the 4-bit table entry 3 (the lone 0x2 nibble), so its
   // fourth step lands directly on the function-set byte.
   function automatic logic [7:0] init_byte(input logic [3:0] idx);
      logic [3:0] t;
      t = (BUS_WIDTH == 8 && idx >= 4'd3) ? idx + 4'd1 : idx;
      case (t)
         4'd0, 4'd1, 4'd2: return 8'h30;
         4'd3:             return 8'h20;
         4'd4:             return C_FSET;
         4'd5:             return 8'h08;
         4'd6:             return 8'h01;
         4'd7:             return 8'h06;
         default:          return 8'h0C;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] init_wait_cnt(input logic [3:0] idx, input logic [7:0] b);
      if (idx == 4'd0) return us_to_cnt(4100);
      if (idx < 4'd4)  return us_to_cnt(100);
      return exec_cnt(b, 1'b0);
   endfunction

   function automatic logic [7:0] row_offset(input logic [1:0] r);
      case (r)
         2'd0:    return 8'h00;
         2'd1:    return 8'h40;
         2'd2:    return 8'h14;
         default: return 8'h54;
      endcase
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       byte_q, byte_d;
   logic             rs_q, rs_d;
   logic             nib_q, nib_d;       // 1 while sending the low nibble
   logic             single_q, single_d; // init step that is one nibble only
   logic [3:0]       idx_q, idx_d;
   logic             done_q, done_d;
   logic [1:0]       row_q, row_d;
   logic [5:0]       col_q, col_d;
   logic             wrap_q, wrap_d;     // set-DDRAM transfer still owed

   logic [1:0]       goto_row;
   logic [5:0]       goto_col;

   always_comb begin
      goto_row = (cmd_row > C_ROW_MAX) ? C_ROW_MAX : cmd_row;
      goto_col = (cmd_col > C_COL_MAX) ? C_COL_MAX : cmd_col;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      byte_d   = byte_q;
      rs_d     = rs_q;
      nib_d    = nib_q;
      single_d = single_q;
      idx_d    = idx_q;
      done_d   = done_q;
      row_d    = row_q;
      col_d    = col_q;
      wrap_d   = wrap_q;

      case (state_q)
         S_PWR_WAIT: begin
            if (cnt_q == '0) begin
               // Go straight into the first init beat so E rises one
               // microsecond after the power-on wait expires.
               idx_d    = 4'd0;
               byte_d   = init_byte(4'd0);
               rs_d     = 1'b0;
               nib_d    = 1'b0;
               single_d = (BUS_WIDTH == 4);
               cnt_d    = C_CNT_1US;
               state_d  = S_SETUP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         S_INIT: begin
            byte_d   = init_byte(idx_q);
            rs_d     = 1'b0;
            nib_d    = 1'b0;
            single_d = (BUS_WIDTH == 4) && (idx_q < 4'd4);
            cnt_d    = C_CNT_1US;
            state_d  = S_SETUP;
         end

         S_IDLE: begin
            if (cmd_valid) begin
               rs_d     = 1'b0;
               nib_d    = 1'b0;
               single_d = 1'b0;
               cnt_d    = C_CNT_1US;
               state_d  = S_SETUP;
               case (cmd_op)
                  2'd0: begin
                     byte_d = cmd_data;
                     rs_d   = 1'b1;
`ifdef LCD_AUTOWRAP_EN
                     if (col_q == C_COL_MAX) begin
                        wrap_d = 1'b1;
                        row_d  = (row_q >= C_ROW_MAX) ? 2'd0 : row_q + 2'd1;
                        col_d  = 6'd0;
                     end else begin
                        col_d = col_q + 6'd1;
                     end
`else
                     if (col_q != C_COL_MAX)
                        col_d = col_q + 6'd1;
`endif
                  end
                  2'd1: begin
                     byte_d = 8'h01;
                     row_d  = 2'd0;
                     col_d  = 6'd0;
                  end
                  2'd2: begin
                     byte_d = 8'h80 | (row_offset(goto_row) + {2'b00, goto_col});
                     row_d  = goto_row;
                     col_d  = goto_col;
                  end
                  default: begin
                     byte_d = cmd_data;
                  end
               endcase
            end
         end

         S_SETUP: begin
            if (cnt_q == '0) begin
               cnt_d   = C_CNT_1US;
               state_d = S_E_HI;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         S_E_HI: begin
            if (cnt_q == '0) begin
               cnt_d   = C_CNT_1US;
               state_d = S_E_LO;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         S_E_LO: begin
            if (cnt_q == '0) begin
               if (BUS_WIDTH == 4 && !single_q && !nib_q) begin
                  nib_d   = 1'b1;
                  cnt_d   = C_CNT_1US;
                  state_d = S_SETUP;
               end else begin
                  cnt_d   = done_q ? exec_cnt(byte_q, rs_q) : init_wait_cnt(idx_q, byte_q);
                  state_d = S_WAIT;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         S_WAIT: begin
            if (cnt_q == '0) begin
               if (!done_q) begin
                  if (idx_q == C_LAST_IDX) begin
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     idx_d   = idx_q + 4'd1;
                     state_d = S_INIT;
                  end
               end else if (wrap_q) begin
                  // Cursor already points at (new row, 0).
                  wrap_d   = 1'b0;
                  byte_d   = 8'h80 | row_offset(row_q);
                  rs_d     = 1'b0;
                  nib_d    = 1'b0;
                  single_d = 1'b0;
                  cnt_d    = C_CNT_1US;
                  state_d  = S_SETUP;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         default: begin
            state_d = S_PWR_WAIT;
            cnt_d   = us_to_cnt(15000);
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= S_PWR_WAIT;
         cnt_q    <= us_to_cnt(15000);
         byte_q   <= 8'h00;
         rs_q     <= 1'b0;
         nib_q    <= 1'b0;
         single_q <= 1'b0;
         idx_q    <= 4'd0;
         done_q   <= 1'b0;
         row_q    <= 2'd0;
         col_q    <= 6'd0;
         wrap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         byte_q   <= byte_d;
         rs_q     <= rs_d;
         nib_q    <= nib_d;
         single_q <= single_d;
         idx_q    <= idx_d;
         done_q   <= done_d;
         row_q    <= row_d;
         col_q    <= col_d;
         wrap_q   <= wrap_d;
      end
   end

   generate
      if (BUS_WIDTH == 8) begin : g_bus8
         assign LCD_D = BUS_WIDTH'(byte_q);
      end else begin : g_bus4
         assign LCD_D = BUS_WIDTH'(nib_q ? byte_q[3:0] : byte_q[7:4]);
      end
   endgenerate

   // E decodes straight from the state register so reset drops it at once.
   assign LCD_E     = (state_q == S_E_HI);
   assign LCD_RS    = rs_q;
   assign cmd_ready = (state_q == S_IDLE);
   assign init_done = done_q;
   assign cur_row   = row_q;
   assign cur_col   = col_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_text_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lcd_text_ctrl
// Purpose  : Directed self-checking bench for lcd_text_ctrl at T1US = 1
//            (4-bit and 8-bit instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_text_ctrl;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic       RST_N;
   logic       cmd_valid;
   logic [1:0] cmd_op;
   logic [7:0] cmd_data;
   logic [1:0] cmd_row;
   logic [5:0] cmd_col;
   logic       cmd_ready, LCD_RS, LCD_E, init_done;
   logic [3:0] LCD_D;
   logic [1:0] cur_row;
   logic [5:0] cur_col;

   logic       c8_valid;
   logic [1:0] c8_op;
   logic [7:0] c8_data;
   logic [1:0] c8_row;
   logic [5:0] c8_col;
   logic       c8_ready, rs8, e8, done8;
   logic [7:0] d8;
   logic [1:0] row8;
   logic [5:0] col8;

   int n_pass;
   int n_total;

   logic [4:0] q4 [$];
   logic [8:0] q8 [$];

   lcd_text_ctrl #(.CLK_FREQ_HZ(1000000), .BUS_WIDTH(4), .COLS(16), .ROWS(2)) dut (
      .CLK(CLK), .RST_N(RST_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_row(cmd_row), .cmd_col(cmd_col),
      .LCD_D(LCD_D), .LCD_RS(LCD_RS), .LCD_E(LCD_E), .init_done(init_done),
      .cur_row(cur_row), .cur_col(cur_col));

   lcd_text_ctrl #(.CLK_FREQ_HZ(1000000), .BUS_WIDTH(8), .COLS(16), .ROWS(2)) dut8 (
      .CLK(CLK), .RST_N(RST_N), .cmd_valid(c8_valid), .cmd_ready(c8_ready),
      .cmd_op(c8_op), .cmd_data(c8_data), .cmd_row(c8_row), .cmd_col(c8_col),
      .LCD_D(d8), .LCD_RS(rs8), .LCD_E(e8), .init_done(done8),
      .cur_row(row8), .cur_col(col8));

   // Panel-side capture: {RS, D} at every E rise.
   always @(posedge LCD_E) q4.push_back({LCD_RS, LCD_D});
   always @(posedge e8)    q8.push_back({rs8, d8});

   // Drives one operation on the 4-bit instance and waits for cmd_ready.
   // ehi = cycles with E high, gap = cycles from last E fall to cmd_ready.
   task automatic do_op(input logic [1:0] op, input logic [7:0] data,
                        input logic [1:0] row, input logic [5:0] col,
                        output int ehi, output int gap, output bit ok);
      int   t;
      int   fall_t;
      logic pe;
      q4.delete();
      cmd_op = op; cmd_data = data; cmd_row = row; cmd_col = col; cmd_valid = 1'b1;
      t = 0;
      while (!cmd_ready && t < 100) begin @(posedge CLK); #1; t++; end
      @(posedge CLK); #1;
      cmd_valid = 1'b0;
      ehi = 0; fall_t = 0; pe = LCD_E; t = 0; ok = 1'b0;
      while (t < 5000) begin
         if (cmd_ready) begin ok = 1'b1; break; end
         @(posedge CLK); #1; t++;
         if (LCD_E) ehi++;
         if (pe && !LCD_E) fall_t = t;
         pe = LCD_E;
      end
      gap = t - fall_t;
   endtask

   task automatic test_reset;
      RST_N = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      n_total++; if (LCD_E !== 1'b0) $display("FAIL reset_E: got %b want 0", LCD_E); else n_pass++;
      n_total++; if (LCD_RS !== 1'b0) $display("FAIL reset_RS: got %b want 0", LCD_RS); else n_pass++;
      n_total++; if (LCD_D !== 4'h0) $display("FAIL reset_D: got %h want 0", LCD_D); else n_pass++;
      n_total++; if (cmd_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", cmd_ready); else n_pass++;
      n_total++; if (init_done !== 1'b0) $display("FAIL reset_done: got %b want 0", init_done); else n_pass++;
      n_total++; if ({cur_row, cur_col} !== 8'h00) $display("FAIL reset_cursor: got %0d,%0d want 0,0", cur_row, cur_col); else n_pass++;
      n_total++; if ({e8, done8, d8} !== 10'h000) $display("FAIL reset_bus8: got E=%b done=%b D=%h want 0", e8, done8, d8); else n_pass++;
   endtask

   // Releases reset, checks power-on timing, holds a raw 0x0C request during
   // init and checks it is accepted afterwards, then decodes both init streams.
   task automatic test_init(input string tag);
      int cyc, first, bad, t;
      logic [4:0] exp4 [16];
      logic [8:0] exp8 [8];
      exp4 = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08, 5'h00, 5'h08,
               5'h00, 5'h01, 5'h00, 5'h06, 5'h00, 5'h0C, 5'h00, 5'h0C};
      exp8 = '{9'h030, 9'h030, 9'h030, 9'h038, 9'h008, 9'h001, 9'h006, 9'h00C};
      @(negedge CLK);
      RST_N = 1'b1;
      q4.delete(); q8.delete();
      cyc = 0; first = 0;
      while (first == 0 && cyc < 20000) begin
         @(posedge CLK); #1; cyc++;
         if (LCD_E) first = cyc;
      end
      n_total++; if (first != 15001) $display("FAIL %s_first_E_cycle: got %0d want 15001", tag, first); else n_pass++;
      n_total++; if ({LCD_RS, LCD_D} !== 5'h03) $display("FAIL %s_first_beat: got RS=%b D=%h want RS=0 D=3", tag, LCD_RS, LCD_D); else n_pass++;
      cmd_op = 2'd3; cmd_data = 8'h0C; cmd_row = 2'd0; cmd_col = 6'd0; cmd_valid = 1'b1;
      bad = 0;
      while (!init_done && cyc < 40000) begin
         @(posedge CLK); #1; cyc++;
         if (cmd_ready && !init_done) bad++;
      end
      n_total++; if (cyc != 22662) $display("FAIL %s_init_done_cycle: got %0d want 22662", tag, cyc); else n_pass++;
      n_total++; if (bad != 0) $display("FAIL %s_ready_during_init: got %0d cycles want 0", tag, bad); else n_pass++;
      @(posedge CLK); #1;
      cmd_valid = 1'b0;
      t = 0;
      while (!cmd_ready && t < 200) begin @(posedge CLK); #1; t++; end
      n_total++; if (!cmd_ready) $display("FAIL %s_held_cmd_done: got ready=0 want 1", tag); else n_pass++;
      t = 0;
      while (!done8 && t < 5000) begin @(posedge CLK); #1; t++; end
      n_total++; if (q4.size() != 16) $display("FAIL %s_beats4_count: got %0d want 16", tag, q4.size()); else n_pass++;
      for (int i = 0; i < 16; i++) begin
         if (i < q4.size()) begin
            n_total++;
            if (q4[i] !== exp4[i]) $display("FAIL %s_beat4[%0d]: got %h want %h", tag, i, q4[i], exp4[i]); else n_pass++;
         end
      end
      n_total++; if (q8.size() != 8) $display("FAIL %s_beats8_count: got %0d want 8", tag, q8.size()); else n_pass++;
      for (int i = 0; i < 8; i++) begin
         if (i < q8.size()) begin
            n_total++;
            if (q8[i] !== exp8[i]) $display("FAIL %s_beat8[%0d]: got %h want %h", tag, i, q8[i], exp8[i]); else n_pass++;
         end
      end
   endtask

   task automatic test_char;
      int ehi, gap; bit ok;
      do_op(2'd0, 8'h41, 2'd0, 6'd0, ehi, gap, ok);
      n_total++; if (!ok) $display("FAIL char_timeout: got ready=0 want 1"); else n_pass++;
      n_total++; if (q4.size() != 2) $display("FAIL char_beats: got %0d want 2", q4.size()); else n_pass++;
      if (q4.size() == 2) begin
         n_total++; if (q4[0] !== 5'h14) $display("FAIL char_hi: got %h want 14", q4[0]); else n_pass++;
         n_total++; if (q4[1] !== 5'h11) $display("FAIL char_lo: got %h want 11", q4[1]); else n_pass++;
      end
      n_total++; if (ehi != 2) $display("FAIL char_E_high_cycles: got %0d want 2", ehi); else n_pass++;
      n_total++; if (gap != 54) $display("FAIL char_ready_gap: got %0d want 54", gap); else n_pass++;
      n_total++; if ({cur_row, cur_col} !== {2'd0, 6'd1}) $display("FAIL char_cursor: got %0d,%0d want 0,1", cur_row, cur_col); else n_pass++;
   endtask

   task automatic test_goto;
      int ehi, gap; bit ok;
      do_op(2'd2, 8'h00, 2'd1, 6'd5, ehi, gap, ok);
      n_total++; if (q4.size() != 2 || q4[0] !== 5'h0C || q4[1] !== 5'h05)
         $display("FAIL goto_1_5_byte: got %0d beats %h %h want 0C 05", q4.size(), q4[0], q4[1]); else n_pass++;
      n_total++; if ({cur_row, cur_col} !== {2'd1, 6'd5}) $display("FAIL goto_1_5_cursor: got %0d,%0d want 1,5", cur_row, cur_col); else n_pass++;
      do_op(2'd2, 8'h00, 2'd3, 6'd50, ehi, gap, ok);
      n_total++; if (q4.size() != 2 || q4[0] !== 5'h0C || q4[1] !== 5'h0F)
         $display("FAIL goto_clamp_byte: got %0d beats %h %h want 0C 0F", q4.size(), q4[0], q4[1]); else n_pass++;
      n_total++; if ({cur_row, cur_col} !== {2'd1, 6'd15}) $display("FAIL goto_clamp_cursor: got %0d,%0d want 1,15", cur_row, cur_col); else n_pass++;
      n_total++; if (gap != 54) $display("FAIL goto_ready_gap: got %0d want 54", gap); else n_pass++;
   endtask

   task automatic test_raw;
      int ehi, gap; bit ok;
      do_op(2'd3, 8'h0E, 2'd0, 6'd0, ehi, gap, ok);
      n_total++; if (q4.size() != 2 || q4[0] !== 5'h00 || q4[1] !== 5'h0E)
         $display("FAIL raw_byte: got %0d beats %h %h want 00 0E", q4.size(), q4[0], q4[1]); else n_pass++;
      n_total++; if ({cur_row, cur_col} !== {2'd1, 6'd15}) $display("FAIL raw_cursor: got %0d,%0d want 1,15", cur_row, cur_col); else n_pass++;
   endtask

   task automatic test_clear;
      int ehi, gap; bit ok;
      do_op(2'd1, 8'h00, 2'd0, 6'd0, ehi, gap, ok);
      n_total++; if (q4.size() != 2 || q4[0] !== 5'h00 || q4[1] !== 5'h01)
         $display("FAIL clear_byte: got %0d beats %h %h want 00 01", q4.size(), q4[0], q4[1]); else n_pass++;
      n_total++; if (gap != 3001) $display("FAIL clear_ready_gap: got %0d want 3001", gap); else n_pass++;
      n_total++; if ({cur_row, cur_col} !== 8'h00) $display("FAIL clear_cursor: got %0d,%0d want 0,0", cur_row, cur_col); else n_pass++;
   endtask

   task automatic test_wrap;
      int ehi, gap; bit ok;
      for (int i = 0; i < 15; i++) do_op(2'd0, 8'h61 + 8'(i), 2'd0, 6'd0, ehi, gap, ok);
      n_total++; if ({cur_row, cur_col} !== {2'd0, 6'd15}) $display("FAIL wrap_pre_cursor: got %0d,%0d want 0,15", cur_row, cur_col); else n_pass++;
      do_op(2'd0, 8'h70, 2'd0, 6'd0, ehi, gap, ok);
`ifdef LCD_AUTOWRAP_EN
      n_total++; if (q4.size() != 4 || q4[0] !== 5'h17 || q4[1] !== 5'h10 || q4[2] !== 5'h0C || q4[3] !== 5'h00)
         $display("FAIL wrap_16th_beats: got %0d beats want 17 10 0C 00", q4.size()); else n_pass++;
      n_total++; if ({cur_row, cur_col} !== {2'd1, 6'd0}) $display("FAIL wrap_16th_cursor: got %0d,%0d want 1,0", cur_row, cur_col); else n_pass++;
`else
      n_total++; if (q4.size() != 2 || q4[0] !== 5'h17 || q4[1] !== 5'h10)
         $display("FAIL wrap_16th_beats: got %0d beats want 17 10", q4.size()); else n_pass++;
      n_total++; if ({cur_row, cur_col} !== {2'd0, 6'd15}) $display("FAIL wrap_16th_cursor: got %0d,%0d want 0,15", cur_row, cur_col); else n_pass++;
`endif
      n_total++; if (gap != 54) $display("FAIL wrap_ready_gap: got %0d want 54", gap); else n_pass++;
      do_op(2'd0, 8'h71, 2'd0, 6'd0, ehi, gap, ok);
      n_total++; if (q4.size() != 2 || q4[0] !== 5'h17 || q4[1] !== 5'h11)
         $display("FAIL wrap_17th_beats: got %0d beats want 17 11", q4.size()); else n_pass++;
`ifdef LCD_AUTOWRAP_EN
      n_total++; if ({cur_row, cur_col} !== {2'd1, 6'd1}) $display("FAIL wrap_17th_cursor: got %0d,%0d want 1,1", cur_row, cur_col); else n_pass++;
`else
      n_total++; if ({cur_row, cur_col} !== {2'd0, 6'd15}) $display("FAIL wrap_17th_cursor: got %0d,%0d want 0,15", cur_row, cur_col); else n_pass++;
`endif
   endtask

   task automatic test_bus8;
      int t;
      q8.delete();
      c8_op = 2'd0; c8_data = 8'h5A; c8_valid = 1'b1;
      t = 0;
      while (!c8_ready && t < 100) begin @(posedge CLK); #1; t++; end
      @(posedge CLK); #1;
      c8_valid = 1'b0;
      t = 0;
      while (!c8_ready && t < 500) begin @(posedge CLK); #1; t++; end
      n_total++; if (q8.size() != 1) $display("FAIL bus8_beats: got %0d want 1", q8.size()); else n_pass++;
      if (q8.size() == 1) begin
         n_total++; if (q8[0] !== 9'h15A) $display("FAIL bus8_data: got %h want 15A", q8[0]); else n_pass++;
      end
      n_total++; if ({row8, col8} !== {2'd0, 6'd1}) $display("FAIL bus8_cursor: got %0d,%0d want 0,1", row8, col8); else n_pass++;
   endtask

   task automatic test_reset_mid;
      int t;
      cmd_op = 2'd0; cmd_data = 8'h5A; cmd_valid = 1'b1;
      t = 0;
      while (!cmd_ready && t < 100) begin @(posedge CLK); #1; t++; end
      @(posedge CLK); #1;
      cmd_valid = 1'b0;
      t = 0;
      while (!LCD_E && t < 20) begin @(posedge CLK); #1; t++; end
      n_total++; if (!LCD_E) $display("FAIL mid_reach_E_HI: got E=0 want 1"); else n_pass++;
      #2 RST_N = 1'b0;
      #1;
      n_total++; if (LCD_E !== 1'b0) $display("FAIL mid_E_async: got %b want 0", LCD_E); else n_pass++;
      n_total++; if (init_done !== 1'b0) $display("FAIL mid_done: got %b want 0", init_done); else n_pass++;
      n_total++; if ({cmd_ready, LCD_RS, cur_row, cur_col} !== 10'h000)
         $display("FAIL mid_state: got ready=%b RS=%b cur=%0d,%0d want 0", cmd_ready, LCD_RS, cur_row, cur_col); else n_pass++;
      repeat (2) @(posedge CLK);
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      RST_N = 1'b0;
      cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 8'h00; cmd_row = 2'd0; cmd_col = 6'd0;
      c8_valid = 1'b0; c8_op = 2'd0; c8_data = 8'h00; c8_row = 2'd0; c8_col = 6'd0;
      test_reset;
      test_init("init");
      test_char;
      test_goto;
      test_raw;
      test_clear;
      test_wrap;
      test_bus8;
      test_reset_mid;
      test_init("rerun");
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lcd_text_ctrl.md
Name: lcd_text_ctrl

Overview:
Parametrised HD44780 character-LCD controller that succeeds the fixed 4-bit init/text block. It runs the power-on init sequence itself, then accepts one operation per valid/ready handshake: write char, clear, goto(row,col) or raw instruction. It tracks the cursor position, with optional automatic line wrap. It drives the LCD pins directly, with E pulse timing generated internally, and sits between the UI/text logic and the panel.

Parameters:
CLK_FREQ_HZ, 50000000, system clock in Hz; T1US = CLK_FREQ_HZ/1000000 (at least 1).
BUS_WIDTH, 4, LCD data bus width; only 4 or 8 are legal.
COLS, 16, visible columns per row (1..40).
ROWS, 2, rows (1..4).

Ports:
CLK  in  1  system clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
cmd_valid  in  1  operation request.
cmd_ready  out  1  high when the controller can accept an operation.
cmd_op  in  2  0 = char, 1 = clear, 2 = goto, 3 = raw instruction.
cmd_data  in  8  character code (op 0) or instruction byte (op 3).
cmd_row  in  2  goto row.
cmd_col  in  6  goto column.
LCD_D  out  BUS_WIDTH  data to the panel (upper nibble D7..D4 when BUS_WIDTH = 4).
LCD_RS  out  1  0 = instruction, 1 = data.
LCD_E  out  1  enable strobe.
init_done  out  1  high once the init sequence completes.
cur_row  out  2  current cursor row.
cur_col  out  6  current cursor column.

Behaviour:
- Reset (asynchronous, RST_N low): LCD_E = 0, LCD_RS = 0, LCD_D = 0, cmd_ready = 0, init_done = 0, cur_row = 0, cur_col = 0; FSM goes to PWR_WAIT.
- Reset asserted mid-transfer: E drops at once, any pending operation is lost, and the full init sequence reruns after release.
- Transfer unit ("beat"), all delays counted from T1US:
  - SETUP: RS/D driven for 1 us.
  - E_HI: E = 1 for 1 us.
  - E_LO: E = 0 for 1 us.
  - Each byte is 2 beats (high nibble first) when BUS_WIDTH = 4, 1 beat when BUS_WIDTH = 8.
  - After the last beat of an operation, WAIT for the exec delay: 3000 us for clear (0x01) and home (0x02/0x03), 53 us otherwise.
- FSM states: PWR_WAIT (15000 us), INIT, IDLE, SETUP, E_HI, E_LO, WAIT.
- INIT sequence, BUS_WIDTH = 4: single-nibble beats 0x3 (wait 4100 us), 0x3 (100 us), 0x3 (100 us), 0x2 (100 us); then full bytes:
  - function set 0x20 | (ROWS > 1 ? 0x08 : 0)
  - 0x08
  - 0x01 (3000 us)
  - 0x06
  - 0x0C
- INIT sequence, BUS_WIDTH = 8: the first four steps are 0x30, 0x30, 0x30, then function set with DL = 1 (0x38 for ROWS > 1). The remaining bytes are identical to the 4-bit case.
- init_done rises in the same cycle the FSM first enters IDLE and stays high until reset.
- Handshake:
  - cmd_ready = 1 only in IDLE.
  - An operation is accepted on a cycle where cmd_valid && cmd_ready; cmd_ready falls the next cycle.
  - cmd_* are sampled only on accept.
  - The first SETUP begins the cycle after accept.
- op 0 (char): RS = 1, byte = cmd_data. Afterwards cur_col increments.
- op 1 (clear): sends 0x01; cur_row = cur_col = 0.
- op 2 (goto):
  - Row clamps to ROWS-1 and column clamps to COLS-1.
  - Sends 0x80 | (row offset + col), with row offsets 0x00, 0x40, 0x14, 0x54.
  - cur_row/cur_col update to the clamped values.
- op 3 (raw): RS = 0, byte sent unchanged; cursor registers are not modified.
- Without wrap, cur_col saturates at COLS-1; further chars are still sent to the panel.
- Counter width is sized for 15000*T1US. Delay counters load on state entry; the state exits when the counter reaches 0.
- cmd_valid asserted during INIT is held off (cmd_ready = 0) and is not dropped.

Optional Feature:
LCD_AUTOWRAP_EN.
- Defined: after a char written at cur_col = COLS-1, the controller appends a set-DDRAM transfer to (next row, col 0) within the same busy period, before cmd_ready returns. The last row wraps to row 0. cur_row/cur_col reflect the new position.
- Undefined: no extra transfer; saturating column as described in Behaviour.

Test Plan:
- Sim with CLK_FREQ_HZ = 1000000 (T1US = 1), BUS_WIDTH = 4, RST_N released at t = 0 -> first E rise at cycle 15001 with LCD_D = 0x3, RS = 0. init_done rises after exactly the specified sequence; bench decodes 0x28, 0x08, 0x01, 0x06, 0x0C.
- After init, char 'A' (0x41) -> nibbles 0x4 then 0x1 with RS = 1; E high 1 cycle each; cmd_ready back after 53 us; cur_col = 1.
- goto row 1, col 5 -> byte 0xC5 sent, cur_row = 1, cur_col = 5. goto row 3, col 50 with ROWS = 2, COLS = 16 -> clamped, byte 0xCF.
- clear -> 0x01, cmd_ready low for at least 3000 cycles after the last E fall; cursor reads 0,0.
- BUS_WIDTH = 8, char 0x5A -> single beat, LCD_D = 0x5A. With LCD_AUTOWRAP_EN, 16 chars on row 0 -> extra 0xC0 transfer, cur_row = 1, cur_col = 0. Without it -> no 0xC0, cur_col stays 15.
- RST_N pulsed low during E_HI of a char -> LCD_E = 0 asynchronously, init_done = 0, and the init sequence restarts from PWR_WAIT.
